// File: rtl/sad_tree_min.sv
// Pipelined radix-4 SAD adder tree with a running-minimum tracker per search block.
// Each tree level is one register stage; tag and flags ride alongside the data.
module sad_tree_min #(
   parameter int N_ELEM = 256,
   parameter int W      = 8,
   parameter int IDX_W  = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic                             in_first,
   input  logic                             in_last,
   input  logic [IDX_W-1:0]                 in_idx,
   input  logic [N_ELEM*W-1:0]              ad,
   output logic                             sum_valid,
   output logic [W+$clog2(N_ELEM)-1:0]      sum,
   output logic [IDX_W-1:0]                 sum_idx,
   output logic                             best_valid,
   output logic [W+$clog2(N_ELEM)-1:0]      best_sad,
   output logic [IDX_W-1:0]                 best_idx
);
   localparam int LEVELS = $clog2(N_ELEM) / 2;
   localparam int SW     = W + 2 * LEVELS;

   genvar gi;
   for (gi = 0; gi <= LEVELS; gi++) begin : lvl
      localparam int CNT = N_ELEM >> (2 * gi);
      localparam int WL  = W + 2 * gi;

      logic [WL-1:0]    val [CNT];
      logic [IDX_W-1:0] idx;
      logic             vld;
      logic             first;
      logic             last;

      if (gi == 0) begin : load
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < CNT; i++) val[i] <= '0;
               idx   <= '0;
               vld   <= 1'b0;
               first <= 1'b0;
               last  <= 1'b0;
            end else begin
               vld   <= in_valid;
               first <= in_valid & in_first;
               last  <= in_valid & in_last;
               if (in_valid) begin
                  idx <= in_idx;
                  for (int i = 0; i < CNT; i++) val[i] <= ad[i*W +: W];
               end
            end
         end
      end else begin : add
         // Each level widens by 2 bits, so four operands can never overflow.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < CNT; i++) val[i] <= '0;
               idx   <= '0;
               vld   <= 1'b0;
               first <= 1'b0;
               last  <= 1'b0;
            end else begin
               vld   <= lvl[gi-1].vld;
               first <= lvl[gi-1].first;
               last  <= lvl[gi-1].last;
               if (lvl[gi-1].vld) begin
                  idx <= lvl[gi-1].idx;
                  for (int i = 0; i < CNT; i++)
                     val[i] <= WL'(lvl[gi-1].val[4*i])   + WL'(lvl[gi-1].val[4*i+1]) +
                               WL'(lvl[gi-1].val[4*i+2]) + WL'(lvl[gi-1].val[4*i+3]);
               end
            end
         end
      end
   end

   logic          sum_first;
   logic          sum_last;
   logic [SW-1:0] run_min;
   logic [IDX_W-1:0] run_idx;
   logic          take;

   assign sum_valid = lvl[LEVELS].vld;
   assign sum       = lvl[LEVELS].val[0];
   assign sum_idx   = lvl[LEVELS].idx;
   assign sum_first = lvl[LEVELS].first;
   assign sum_last  = lvl[LEVELS].last;

   // A first candidate always restarts; otherwise only a strictly smaller SAD wins.
   always_comb begin
      take = 1'b0;
      take = sum_first || (sum < run_min);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_min    <= '1;
         run_idx    <= '0;
         best_valid <= 1'b0;
         best_sad   <= '0;
         best_idx   <= '0;
      end else begin
         best_valid <= sum_valid & sum_last;
         if (sum_valid && take) begin
            run_min <= sum;
            run_idx <= sum_idx;
         end
         if (sum_valid && sum_last) begin
            best_sad <= take ? sum : run_min;
            best_idx <= take ? sum_idx : run_idx;
         end
      end
   end
endmodule

// File: tb/tb_sad_tree_min.sv
// Scoreboard bench for sad_tree_min: stimulus pushes expected results,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_sad_tree_min;
   localparam int N_ELEM = 256;
   localparam int W      = 8;
   localparam int IDX_W  = 8;
   localparam int NW     = N_ELEM * W;
   localparam int SW     = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_first;
   logic              in_last;
   logic [IDX_W-1:0]  in_idx;
   logic [NW-1:0]     ad;
   logic              sum_valid;
   logic [SW-1:0]     sum;
   logic [IDX_W-1:0]  sum_idx;
   logic              best_valid;
   logic [SW-1:0]     best_sad;
   logic [IDX_W-1:0]  best_idx;

   sad_tree_min #(.N_ELEM(N_ELEM), .W(W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_idx(in_idx), .ad(ad), .sum_valid(sum_valid),
      .sum(sum), .sum_idx(sum_idx), .best_valid(best_valid),
      .best_sad(best_sad), .best_idx(best_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int idx;
      int cyc;
   } exp_t;

   exp_t sum_q[$];
   exp_t best_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_issue = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [NW-1:0] mk(input int sad);
      logic [NW-1:0] v;
      int rem;
      v   = '0;
      rem = sad;
      for (int i = 0; i < N_ELEM; i++) begin
         v[i*W +: W] = (rem > 255) ? 8'd255 : 8'(rem);
         rem = (rem > 255) ? rem - 255 : 0;
      end
      return v;
   endfunction

   task automatic drive(input logic [NW-1:0] v, input int exp_sum, input int idx,
                        input bit f, input bit l, input bit track);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      in_idx   = IDX_W'(idx);
      ad       = v;
      last_issue = cyc;
      if (track) begin
         e.val = exp_sum; e.idx = idx; e.cyc = cyc + 5;
         sum_q.push_back(e);
      end
      $display("issue idx %0d sad %0d first %0d last %0d tracked %0d", idx, exp_sum, f, l, track);
   endtask

   task automatic send(input int sad, input int idx, input bit f, input bit l);
      drive(mk(sad), sad, idx, f, l, 1'b1);
   endtask

   task automatic push_best(input int val, input int idx);
      exp_t e;
      e.val = val; e.idx = idx; e.cyc = last_issue + 6;
      best_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_first = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // Monitor
   int last_sum = 0, last_sidx = 0, last_best = 0, last_bidx = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         last_sum = 0; last_sidx = 0; last_best = 0; last_bidx = 0;
      end else begin
         if (sum_valid) begin
            if (sum_q.size() == 0) begin
               chk("unexpected_sum_valid", 1, 0);
            end else begin
               e = sum_q.pop_front();
               chk("sum", sum, e.val);
               chk("sum_idx", sum_idx, e.idx);
               chk("sum_latency", cyc, e.cyc);
               $display("sum %0d idx %0d at cycle %0d", sum, sum_idx, cyc);
            end
            last_sum = int'(sum); last_sidx = int'(sum_idx);
         end else begin
            chk("sum_hold", sum, last_sum);
            chk("sum_idx_hold", sum_idx, last_sidx);
         end
         if (best_valid) begin
            if (best_q.size() == 0) begin
               chk("unexpected_best_valid", 1, 0);
            end else begin
               e = best_q.pop_front();
               chk("best_sad", best_sad, e.val);
               chk("best_idx", best_idx, e.idx);
               chk("best_latency", cyc, e.cyc);
               $display("best %0d idx %0d at cycle %0d", best_sad, best_idx, cyc);
            end
            last_best = int'(best_sad); last_bidx = int'(best_idx);
         end else begin
            chk("best_sad_hold", best_sad, last_best);
            chk("best_idx_hold", best_idx, last_bidx);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_sum_valid"}, sum_valid, 0);
      chk({tag, "_sum"}, sum, 0);
      chk({tag, "_sum_idx"}, sum_idx, 0);
      chk({tag, "_best_valid"}, best_valid, 0);
      chk({tag, "_best_sad"}, best_sad, 0);
      chk({tag, "_best_idx"}, best_idx, 0);
   endtask

   initial begin
      logic [NW-1:0] v;
      int s;
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      in_idx = '0; ad = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full-scale single candidate block
      send(65280, 7, 1'b1, 1'b1);
      push_best(65280, 7);
      idle(8);

      // Streaming random vectors, no block markers
      for (int k = 0; k < 20; k++) begin
         s = 0;
         for (int i = 0; i < N_ELEM; i++) begin
            v[i*W +: W] = 8'($urandom_range(0, 255));
            s += int'(v[i*W +: W]);
         end
         drive(v, s, 100 + k, 1'b0, 1'b0, 1'b1);
      end
      idle(8);

      // Tie keeps earlier candidate
      send(300, 0, 1'b1, 1'b0);
      send(120, 1, 1'b0, 1'b0);
      send(120, 2, 1'b0, 1'b0);
      send(500, 3, 1'b0, 1'b1);
      push_best(120, 1);
      idle(8);

      // Gaps in valid
      send(77, 20, 1'b0, 1'b0);
      idle(2);
      send(88, 21, 1'b0, 1'b0);
      idle(8);

      // Back-to-back blocks
      send(50, 2, 1'b1, 1'b0);
      send(40, 3, 1'b0, 1'b1);
      push_best(40, 3);
      send(10, 9, 1'b1, 1'b1);
      push_best(10, 9);
      idle(8);

      // Reset with three untracked candidates in flight
      drive(mk(5), 5, 30, 1'b1, 1'b0, 1'b0);
      drive(mk(6), 6, 31, 1'b0, 1'b0, 1'b0);
      drive(mk(7), 7, 32, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      idle(8);

      // After reset, a last without first compares against all-ones
      send(65280, 5, 1'b0, 1'b1);
      push_best(65280, 5);
      send(1000, 4, 1'b1, 1'b1);
      push_best(1000, 4);
      idle(2);

      for (int t = 0; t < 60 && (sum_q.size() != 0 || best_q.size() != 0); t++)
         @(posedge clk);
      chk("drain_sum_q", sum_q.size(), 0);
      chk("drain_best_q", best_q.size(), 0);
      idle(3);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sad_tree_min.md
# sad_tree_min

Parametrised, fully pipelined sum-of-absolute-differences adder tree with an integrated running-minimum tracker for inter-prediction motion search. It accepts one vector of N absolute differences per cycle, reduces it through a radix-4 registered tree, and tags each result with a candidate index. Across a search block delimited by first/last markers, it tracks the smallest SAD and its index. It sits between the absolute-difference array and the motion-vector decision logic.

## Interface
- N_ELEM, 256, number of absolute-difference elements; power of 4, minimum 4
- W, 8, width of each element
- IDX_W, 8, width of the candidate tag
- Derived: LEVELS = log4(N_ELEM); SW = W + 2*LEVELS (sum width; 16 at defaults)

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  in  1  ad/in_idx/in_first/in_last are valid this cycle
- in_first  in  1  first candidate of a search block (qualified by in_valid)
- in_last  in  1  last candidate of a search block (qualified by in_valid)
- in_idx  in  IDX_W  candidate tag
- ad  in  N_ELEM*W  element i at bits [(i+1)*W-1 : i*W], unsigned
- sum_valid  out  1  sum/sum_idx valid
- sum  out  SW  SAD of one candidate
- sum_idx  out  IDX_W  tag of sum
- best_valid  out  1  one-cycle pulse: search block result ready
- best_sad  out  SW  minimum SAD of completed block
- best_idx  out  IDX_W  tag of that minimum

## Operation
- No backpressure; one vector accepted per cycle; throughput 1/cycle.
- Stage 0: register ad, in_idx, in_first, in_last, in_valid.
- Stages 1..LEVELS: each adds groups of 4 previous-stage values, width +2 bits per level; no truncation or saturation anywhere.
- Valid, tag, first and last bits travel alongside the data, one register per stage.
- Data/tag registers at a stage load only when that stage's incoming valid is 1; otherwise they hold. sum and sum_idx therefore hold their last value while sum_valid = 0.
- Min tracker (registers run_min[SW], run_idx[IDX_W]), on each cycle with sum_valid = 1:
  - sum_first = 1: run_min <= sum, run_idx <= sum_idx (unconditional restart).
  - else if sum < run_min (strict): update both; ties keep the earlier candidate.
  - else: hold.
  - sum_last = 1: next cycle best_valid = 1, best_sad/best_idx = the minimum including this candidate (first and last on the same candidate gives that candidate).
- best_sad/best_idx update only with best_valid and hold otherwise.
- A candidate with no preceding first (after reset) compares against run_min reset value all-ones.
- Reset mid-operation: all in-flight candidates discarded; no sum_valid/best_valid for them.

## Timing
- Latency: vector sampled at edge E0 -> sum_valid high in the cycle after edge E0+LEVELS (LEVELS+1 cycles; 5 at defaults).
- best_valid: one cycle after the sum_valid cycle carrying last (LEVELS+2 cycles from input).
- Back-to-back blocks: last of block A followed directly by first of block B. A's best_valid and B's restart coincide without interference.
- Reset values: sum_valid 0, sum 0, sum_idx 0, best_valid 0, best_sad 0, best_idx 0; all pipeline data/flags 0; run_min all-ones, run_idx 0.
- in_first/in_last/in_idx are ignored when in_valid = 0.

## Test plan
- Defaults, single vector with all 256 elements = 255, first = last = 1, idx = 7 -> 5 cycles later sum = 65280, sum_idx = 7; next cycle best_valid = 1, best_sad = 65280, best_idx = 7.
- Streaming: 20 consecutive random vectors -> 20 consecutive sum_valid cycles, each matching the reference sum in order; no bubbles.
- Block of 4 candidates with SADs 300, 120, 120, 500 (idx 0..3) -> best_sad = 120, best_idx = 1 (tie keeps earlier); best_valid exactly once.
- Gaps: vectors with in_valid pattern 1,0,0,1 -> sum_valid pattern 1,0,0,1 with the same spacing; sum holds its value during the gap cycles.
- Back-to-back blocks {50 idx 2, 40 idx 3} then {10 idx 9} -> best pulses carrying (40,3) then (10,9) on consecutive valid-last cycles.
- rst_n low for 1 cycle while 3 vectors are in flight -> no sum_valid/best_valid afterwards; all outputs 0; next block behaves as after power-up.
